cp0_exc: RTL and testbench

CP0_EXC -- requirements
Module: cp0_exc

---
 rtl/cp0_exc.sv | 151 +++++++++++++++
 tb/tb_cp0_exc.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc.sv
// CP0 exception unit: SR/Cause/EPC/PRId, exception/interrupt entry, eret.
// Optional Count/Compare timer on IP[15] when CP0_TIMER_EN is defined.
module cp0_exc #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter logic [31:0] PRID_VAL     = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PCM,
    input  logic [4:0]  ExcCodeM,
    input  logic        bdM,
    input  logic [5:0]  HWInt,
    input  logic        We,
    input  logic [4:0]  Addr,
    input  logic [31:0] Din,
    input  logic        EretM,
    output logic [31:0] Dout,
    output logic        exp_out,
    output logic [31:0] EPC,
    output logic [31:0] HandlerPC
);

    localparam int unsigned DW = 32;
    localparam logic [4:0] A_COUNT   = 5'd9;
    localparam logic [4:0] A_COMPARE = 5'd11;
    localparam logic [4:0] A_SR      = 5'd12;
    localparam logic [4:0] A_CAUSE   = 5'd13;
    localparam logic [4:0] A_EPC     = 5'd14;
    localparam logic [4:0] A_PRID    = 5'd15;

    typedef enum logic {NORMAL = 1'b0, HANDLER = 1'b1} exl_state_e;

    exl_state_e      state_q, state_d;
    logic [5:0]      im_q, im_d;
    logic            ie_q, ie_d;
    logic            bd_q, bd_d;
    logic [5:0]      ip_q, ip_d;
    logic [4:0]      exc_code_q, exc_code_d;
    logic [DW-1:0]   epc_q, epc_d;

    logic            exl;
    logic            int_pend;
    logic            mtc_we;
    logic            timer_ip;
    logic [DW-1:0]   pc_sel;

    assign exl       = (state_q == HANDLER);
    assign int_pend  = (|(ip_q & im_q)) & ie_q & ~exl;
    assign exp_out   = int_pend | ((ExcCodeM != 5'd0) & ~exl);
    assign mtc_we    = We & ~exp_out;
    assign EPC       = epc_q;
    assign HandlerPC = HANDLER_ADDR;
    assign pc_sel    = bdM ? (PCM - DW'(4)) : PCM;

`ifdef CP0_TIMER_EN
    logic [DW-1:0] count_q, count_d;
    logic [DW-1:0] compare_q, compare_d;
    logic          tflag_q, tflag_d;

    // Free-running counter; the match flag stays set until Compare is rewritten
    always_comb begin
        count_d   = count_q + DW'(1);
        compare_d = compare_q;
        tflag_d   = tflag_q;
        if (count_q == compare_q) tflag_d = 1'b1;
        if (mtc_we && Addr == A_COUNT) count_d = Din;
        if (mtc_we && Addr == A_COMPARE) begin
            compare_d = Din;
            tflag_d   = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            count_q   <= '0;
            compare_q <= '0;
            tflag_q   <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            tflag_q   <= tflag_d;
        end
    end

    assign timer_ip = tflag_q;
`else
    assign timer_ip = 1'b0;
`endif

    // Exception entry wins over mtc0; eret is applied after any SR write
    always_comb begin
        state_d    = state_q;
        im_d       = im_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        ip_d       = HWInt | {timer_ip, 5'b0};
        if (exp_out) begin
            state_d    = HANDLER;
            bd_d       = bdM;
            exc_code_d = int_pend ? 5'd0 : ExcCodeM;
            epc_d      = pc_sel & 32'hFFFF_FFFC;
        end else begin
            if (mtc_we && Addr == A_SR) begin
                im_d    = Din[15:10];
                ie_d    = Din[0];
                state_d = Din[1] ? HANDLER : NORMAL;
            end
            if (mtc_we && Addr == A_EPC) epc_d = Din;
            if (EretM) state_d = NORMAL;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= NORMAL;
            im_q       <= '0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_q       <= '0;
            exc_code_q <= '0;
            epc_q      <= '0;
        end else begin
            state_q    <= state_d;
            im_q       <= im_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_q       <= ip_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

    // mfc0 read mux, pre-edge state only
    always_comb begin
        Dout = '0;
        case (Addr)
            A_SR:    Dout = {16'b0, im_q, 8'b0, exl, ie_q};
            A_CAUSE: Dout = {bd_q, 15'b0, ip_q, 3'b0, exc_code_q, 2'b0};
            A_EPC:   Dout = epc_q;
            A_PRID:  Dout = PRID_VAL;
`ifdef CP0_TIMER_EN
            A_COUNT:   Dout = count_q;
            A_COMPARE: Dout = compare_q;
`endif
            default: Dout = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc.sv
// Self-checking bench for cp0_exc: directed scenarios plus a randomized run
// against a word-level reference model of SR/Cause/EPC.
module tb_cp0_exc;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] PCM = '0;
    logic [4:0]  ExcCodeM = '0;
    logic        bdM = 1'b0;
    logic [5:0]  HWInt = '0;
    logic        We = 1'b0;
    logic [4:0]  Addr = '0;
    logic [31:0] Din = '0;
    logic        EretM = 1'b0;
    logic [31:0] Dout;
    logic        exp_out;
    logic [31:0] EPC;
    logic [31:0] HandlerPC;

    int checks = 0;
    int errors = 0;

    cp0_exc dut (
        .Clk(Clk), .Reset(Reset), .PCM(PCM), .ExcCodeM(ExcCodeM), .bdM(bdM),
        .HWInt(HWInt), .We(We), .Addr(Addr), .Din(Din), .EretM(EretM),
        .Dout(Dout), .exp_out(exp_out), .EPC(EPC), .HandlerPC(HandlerPC)
    );

    always #5 Clk = ~Clk;

    task automatic idle();
        PCM = '0; ExcCodeM = '0; bdM = 1'b0; HWInt = '0;
        We = 1'b0; Addr = '0; Din = '0; EretM = 1'b0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        We = 1'b1; Addr = a; Din = d;
        tick();
        We = 1'b0;
    endtask

    task automatic chk_reg(input string name, input logic [4:0] a, input logic [31:0] exp_v);
        Addr = a;
        #1;
        checks++;
        if (Dout !== exp_v) begin
            errors++;
            $display("FAIL %s: reg %0d got %h expected %h", name, a, Dout, exp_v);
        end
    endtask

    task automatic do_reset();
        idle();
        Reset = 1'b1;
        #1;
        Reset = 1'b0;
        #2;
    endtask

    task automatic release_reset();
        @(negedge Clk);
        Reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (exp_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_exp: got %b expected 0", exp_out);
        end
        chk_reg("reset_sr", 5'd12, 32'h0);
        chk_reg("reset_cause", 5'd13, 32'h0);
        chk_reg("reset_epc", 5'd14, 32'h0);
        checks++;
        if (HandlerPC !== 32'h0000_4180) begin
            errors++;
            $display("FAIL handler_pc: got %h expected 00004180", HandlerPC);
        end
        release_reset();
    endtask

    task automatic test_reg_masks();
        do_reset(); release_reset();
        mtc0(5'd12, 32'hFFFF_FFFF);
        chk_reg("sr_mask", 5'd12, 32'h0000_FC03);
        mtc0(5'd13, 32'hFFFF_FFFF);
        chk_reg("cause_ro", 5'd13, 32'h0);
        mtc0(5'd15, 32'h1234_5678);
        chk_reg("prid", 5'd15, 32'h0);
        mtc0(5'd14, 32'hDEAD_BEEF);
        chk_reg("epc_write", 5'd14, 32'hDEAD_BEEF);
`ifndef CP0_TIMER_EN
        mtc0(5'd9, 32'h55);
        chk_reg("count_absent", 5'd9, 32'h0);
        mtc0(5'd11, 32'h66);
        chk_reg("compare_absent", 5'd11, 32'h0);
`endif
        chk_reg("unimpl", 5'd3, 32'h0);
    endtask

    task automatic test_sync_exc();
        do_reset(); release_reset();
        mtc0(5'd12, 32'h1);
        ExcCodeM = 5'd4; PCM = 32'h3010; bdM = 1'b0;
        #1;
        checks++;
        if (exp_out !== 1'b1) begin
            errors++;
            $display("FAIL sync_exp: got %b expected 1", exp_out);
        end
        tick();
        idle();
        chk_reg("sync_epc", 5'd14, 32'h3010);
        chk_reg("sync_cause", 5'd13, 32'h0000_0010);
        chk_reg("sync_sr", 5'd12, 32'h0000_0003);
        checks++;
        if (EPC !== 32'h3010) begin
            errors++;
            $display("FAIL sync_epc_port: got %h expected 00003010", EPC);
        end
    endtask

    task automatic test_delay_slot();
        do_reset(); release_reset();
        mtc0(5'd12, 32'h1);
        ExcCodeM = 5'd10; PCM = 32'h3024; bdM = 1'b1;
        tick();
        idle();
        chk_reg("ds_epc", 5'd14, 32'h3020);
        chk_reg("ds_cause", 5'd13, 32'h8000_0028);
    endtask

    task automatic test_int_mask();
        do_reset(); release_reset();
        mtc0(5'd12, 32'h401);
        HWInt = 6'b000001;
        tick();
        checks++;
        if (exp_out !== 1'b1) begin
            errors++;
            $display("FAIL int_unmasked: got %b expected 1", exp_out);
        end
        ExcCodeM = 5'd7;
        tick();
        ExcCodeM = 5'd0;
        chk_reg("int_cause", 5'd13, 32'h0000_0400);
        chk_reg("int_sr", 5'd12, 32'h0000_0403);
        do_reset(); release_reset();
        mtc0(5'd12, 32'h400);
        HWInt = 6'b000001;
        tick();
        tick();
        checks++;
        if (exp_out !== 1'b0) begin
            errors++;
            $display("FAIL int_masked: got %b expected 0", exp_out);
        end
        idle();
    endtask

    task automatic test_exl_eret();
        do_reset(); release_reset();
        mtc0(5'd12, 32'h403);
        HWInt = 6'b000001;
        tick();
        ExcCodeM = 5'd12;
        #1;
        checks++;
        if (exp_out !== 1'b0) begin
            errors++;
            $display("FAIL exl_block: got %b expected 0", exp_out);
        end
        ExcCodeM = 5'd0;
        EretM = 1'b1;
        tick();
        EretM = 1'b0;
        chk_reg("eret_sr", 5'd12, 32'h0000_0401);
        checks++;
        if (exp_out !== 1'b1) begin
            errors++;
            $display("FAIL eret_int: got %b expected 1", exp_out);
        end
        idle();
        tick();
        // eret together with an SR write: write lands, then EXL is cleared
        do_reset(); release_reset();
        mtc0(5'd12, 32'h2);
        We = 1'b1; Addr = 5'd12; Din = 32'h0000_0803; EretM = 1'b1;
        tick();
        idle();
        chk_reg("eret_mtc0", 5'd12, 32'h0000_0801);
    endtask

    task automatic test_write_priority();
        do_reset(); release_reset();
        mtc0(5'd12, 32'h1);
        We = 1'b1; Addr = 5'd14; Din = 32'h5000;
        ExcCodeM = 5'd4; PCM = 32'h3000;
        tick();
        idle();
        chk_reg("wr_prio_epc", 5'd14, 32'h3000);
    endtask

`ifdef CP0_TIMER_EN
    task automatic test_timer();
        bit seen;
        do_reset(); release_reset();
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd0);
        mtc0(5'd12, 32'h8001);
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            if (exp_out === 1'b1) seen = 1'b1;
            else tick();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL timer_fire: got no request expected exp_out=1");
        end
        tick();
        mtc0(5'd11, 32'd1000);
        mtc0(5'd12, 32'h8001);
        tick();
        checks++;
        if (exp_out !== 1'b0) begin
            errors++;
            $display("FAIL timer_clear: got %b expected 0", exp_out);
        end
    endtask
`else
    // Word-level reference: SR/Cause/EPC as architectural 32-bit registers
    task automatic test_random();
        logic [31:0] m_sr, m_cause, m_epc, n_sr, n_cause, n_epc, rd;
        logic [31:0] tgt;
        bit pend, m_exp;
        int addr_pick;
        do_reset(); release_reset();
        m_sr = '0; m_cause = '0; m_epc = '0;
        for (int it = 0; it < 400; it++) begin
            PCM      = $urandom;
            ExcCodeM = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'd0;
            bdM      = 1'($urandom);
            HWInt    = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            We       = ($urandom_range(0, 2) == 0);
            addr_pick = $urandom_range(0, 7);
            case (addr_pick)
                0, 1: Addr = 5'd12;
                2: Addr = 5'd13;
                3, 4: Addr = 5'd14;
                5: Addr = 5'd15;
                default: Addr = 5'($urandom);
            endcase
            Din   = $urandom;
            EretM = ($urandom_range(0, 5) == 0);
            #1;
            pend  = ((m_cause[15:10] & m_sr[15:10]) != 0) && m_sr[0] && !m_sr[1];
            m_exp = pend || (ExcCodeM != 0 && !m_sr[1]);
            case (Addr)
                5'd12: rd = m_sr;
                5'd13: rd = m_cause;
                5'd14: rd = m_epc;
                default: rd = 32'h0;
            endcase
            checks++;
            if (exp_out !== m_exp) begin
                errors++;
                $display("FAIL rand_exp[%0d]: got %b expected %b", it, exp_out, m_exp);
            end
            checks++;
            if (Dout !== rd) begin
                errors++;
                $display("FAIL rand_dout[%0d]: reg %0d got %h expected %h", it, Addr, Dout, rd);
            end
            n_sr = m_sr; n_epc = m_epc;
            if (m_exp) begin
                n_sr  = m_sr | 32'h2;
                tgt   = bdM ? PCM - 32'd4 : PCM;
                n_epc = {tgt[31:2], 2'b00};
                n_cause = ({31'b0, bdM} << 31) | ({26'b0, HWInt} << 10)
                        | ({27'b0, (pend ? 5'd0 : ExcCodeM)} << 2);
            end else begin
                if (We && Addr == 5'd12) n_sr = Din & 32'h0000_FC03;
                if (We && Addr == 5'd14) n_epc = Din;
                if (EretM) n_sr = n_sr & ~32'h2;
                n_cause = (m_cause & ~32'h0000_FC00) | ({26'b0, HWInt} << 10);
            end
            tick();
            m_sr = n_sr; m_cause = n_cause; m_epc = n_epc;
        end
        idle();
    endtask
`endif

    initial begin
        test_reset();
        test_reg_masks();
        test_sync_exc();
        test_delay_slot();
        test_int_mask();
        test_exl_eret();
        test_write_priority();
`ifdef CP0_TIMER_EN
        test_timer();
`else
        test_random();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
